inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Fetch stage of the Tomasulo core.
- Owns the PC and drives the instruction RAM address. The RAM read is combinational with zero latency, so `inst_i` is valid in the same cycle as `pc_o`.
- Buffers each {pc, instruction} pair in a small FIFO that the issue/dispatch stage drains with a valid/ready handshake.
- A flush from the branch/commit unit clears the queue and redirects the PC.

Parameters:
- `DEPTH`, 4, number of queue entries. Must be a power of 2, minimum 2.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk` input 1: clock, all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `pc_o` output 32: fetch address to the instruction RAM, equal to the PC register.
- `inst_i` input 32: instruction word returned by the RAM for `pc_o`, same cycle.
- `flush_i` input 1: redirect request, wins over all other activity.
- `flush_pc_i` input 32: redirect target.
- `iq_valid_o` output 1: the queue head is valid.
- `iq_ready_i` input 1: the consumer accepts the head this cycle.
- `iq_inst_o` output 32: instruction at the head.
- `iq_pc_o` output 32: PC of the head instruction.
- `iq_pred_taken_o` output 1: the head was fetched with a predicted-taken redirect.
- `count_o` output log2(DEPTH)+1: current occupancy.

Behaviour:
- **Reset** (`rst`=1 at the edge):
  - PC = `RESET_PC`.
  - Read and write pointers = 0, count = 0.
  - `iq_valid_o`=0, `count_o`=0.
  - `iq_inst_o`, `iq_pc_o` and `iq_pred_taken_o` are 0 whenever the queue is empty.
  - Reset asserted mid-operation discards all entries; the next cycle behaves as the first cycle after reset.
- **Storage:**
  - Register array of `DEPTH` entries, each {pc[31:0], inst[31:0], pred[0]}.
  - Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - full = (count == DEPTH); empty = (count == 0).
- **Enqueue condition:** enq = !flush_i && !full, where full is taken from the registered count.
  - Enqueue is not allowed on a full queue, even when a dequeue happens in the same cycle.
- **On enqueue:**
  - Write {pc_o, inst_i, pred} to the write-pointer slot and increment the write pointer.
  - PC becomes next_pc, which is PC+4 with 32-bit wrap (0xFFFF_FFFC+4 = 0).
- **When not enqueuing:** the PC holds, and so does `pc_o`. The RAM is re-read the following cycle.
- **Dequeue:** deq = !flush_i && iq_ready_i && !empty.
  - The head is driven combinationally from the read-pointer slot.
  - A dequeue increments the read pointer.
- **Count update:** count changes by +1, -1 or 0 for enq-only, deq-only, or both/neither.
- **Latency:** an instruction enqueued at edge N is visible at the head from cycle N+1 when the queue was empty. There is no same-cycle bypass.
- **Flush** (`flush_i`=1, not in reset):
  - Pointers and count go to 0.
  - PC = {flush_pc_i[31:2], 2'b00}; misaligned low bits are silently cleared.
  - No enqueue and no dequeue that cycle. The value of `iq_ready_i` is ignored.
  - Back-to-back flushes: the last one wins, and the queue stays empty throughout.
- **Precedence:** rst > flush_i > normal enq/deq.
- **Outputs:** `iq_valid_o` = !empty; `count_o` = count.

Optional Feature:
- Macro: `FETCH_JAL_PREDICT_EN`.
- **Defined:**
  - When an enqueued `inst_i[6:0]` == 7'b1101111 (JAL), next_pc = pc_o + sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - That entry's pred bit = 1; every other entry has pred = 0.
  - A flush still overrides.
- **Undefined:**
  - next_pc is always PC+4 and pred is always 0, so `iq_pred_taken_o` is constant 0.
  - The port remains present.

Test Plan:
- **Reset then stall:** release rst with `iq_ready_i`=0 and RAM word0=0xfe010113, word1=0x00112e23.
  - After 4 edges: `count_o`=4, `pc_o`=0x10 and held.
  - Head: inst=0xfe010113, pc=0x0, `iq_valid_o`=1.
- **Drain one from full:** starting full, assert `iq_ready_i` for 1 cycle.
  - `count_o`=3, head inst=0x00112e23, pc=0x4.
  - The next cycle enqueues pc 0x10, so count returns to 4.
- **Streaming:** hold `iq_ready_i`=1 from empty.
  - After the first fill cycle, `iq_valid_o` stays 1 and `count_o` stays 1.
  - Head pc advances by 4 each cycle: 0x0, 0x4, 0x8.
- **Flush with dequeue:** queue holds 3 entries, `iq_ready_i`=1, `flush_i`=1, `flush_pc_i`=0x103.
  - Next cycle: `count_o`=0, `iq_valid_o`=0, `pc_o`=0x100.
  - One cycle later the head pc is 0x100.
- **JAL predict:** with `FETCH_JAL_PREDICT_EN`, the word at 0x24 is 0x0300006f.
  - After it enqueues, `pc_o`=0x54.
  - That entry has `iq_pred_taken_o`=1 when at the head.
  - Without the macro, `pc_o`=0x28 and pred=0.
- **Reset mid-stream:** assert rst with 2 entries queued.
  - Next cycle: `count_o`=0, `pc_o`=`RESET_PC`, all head outputs 0.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// Issue-side handshake of the fetch queue.
// master: fetch queue (drives head), slave: issue stage.
interface inst_fetch_queue_if;
  logic        iq_valid_o;
  logic        iq_ready_i;
  logic [31:0] iq_inst_o;
  logic [31:0] iq_pc_o;
  logic        iq_pred_taken_o;

  modport master (
    output iq_valid_o,
    input  iq_ready_i,
    output iq_inst_o,
    output iq_pc_o,
    output iq_pred_taken_o
  );

  modport slave (
    input  iq_valid_o,
    output iq_ready_i,
    input  iq_inst_o,
    input  iq_pc_o,
    input  iq_pred_taken_o
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the PC, reads the instruction RAM and
// buffers {pc, inst, pred} entries for the issue stage.
// Ports: clk, rst (sync, active-high), pc_o/inst_i (RAM),
// flush_i/flush_pc_i (redirect), iq (head handshake),
// count_o (occupancy).
// Option: FETCH_JAL_PREDICT_EN enables JAL target prediction.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              pc_o,
  input  logic [31:0]              inst_i,
  input  logic                     flush_i,
  input  logic [31:0]              flush_pc_i,
  inst_fetch_queue_if.master       iq,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [31:0] pc_q;
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic [64:0]   mem [DEPTH];

  logic        full;
  logic        empty;
  logic        enq;
  logic        deq;
  logic [31:0] next_pc;
  logic        pred;
  logic [64:0] head;
  logic        unused_bits;

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign enq   = !flush_i && !full;
  assign deq   = !flush_i && iq.iq_ready_i && !empty;

  // Redirect targets are word aligned; the low bits are dropped.
  assign unused_bits = ^flush_pc_i[1:0];

  always_comb begin
    next_pc = pc_q + 32'd4;
    pred    = 1'b0;
`ifdef FETCH_JAL_PREDICT_EN
    if (inst_i[6:0] == 7'b1101111) begin
      next_pc = pc_q + {{11{inst_i[31]}}, inst_i[31],
                        inst_i[19:12], inst_i[20],
                        inst_i[30:21], 1'b0};
      pred    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      pc_q  <= {flush_pc_i[31:2], 2'b00};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (enq) begin
        wr_q <= wr_q + 1'b1;
        pc_q <= next_pc;
      end
      if (deq) begin
        rd_q <= rd_q + 1'b1;
      end
      case ({enq, deq})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_q] <= {pc_q, inst_i, pred};
    end
  end

  assign head = empty ? '0 : mem[rd_q];

  assign pc_o               = pc_q;
  assign count_o            = cnt_q;
  assign iq.iq_valid_o      = !empty;
  assign iq.iq_pc_o         = head[64:33];
  assign iq.iq_inst_o       = head[32:1];
  assign iq.iq_pred_taken_o = head[0];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue against a queue model.
// Directed test-plan scenarios run first, then random traffic.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        flush;
  logic [31:0] flush_pc;
  logic [2:0]  count;

  logic [31:0] ram [256];

  inst_fetch_queue_if iq ();

  inst_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_o       (pc),
    .inst_i     (inst),
    .flush_i    (flush),
    .flush_pc_i (flush_pc),
    .iq         (iq.master),
    .count_o    (count)
  );

  always #5 clk = ~clk;

  assign inst = ram[pc[9:2]];

  int   vecs = 0;
  int   errs = 0;
  ent_t mq[$];
  logic [31:0] mpc;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic is_jal(input logic [31:0] w);
`ifdef FETCH_JAL_PREDICT_EN
    return w[6:0] == 7'h6f;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] nxt(input logic [31:0] a,
                                      input logic [31:0] w);
    logic [31:0] off;
    off = {{11{w[31]}}, w[31], w[19:12], w[20],
           w[30:21], 1'b0};
    return is_jal(w) ? a + off : a + 32'd4;
  endfunction

  // Advance the model with the current inputs, clock once,
  // then compare every visible output.
  task automatic step();
    bit   e;
    bit   d;
    ent_t x;
    logic [31:0] w;
    if (rst) begin
      mq.delete();
      mpc = RPC;
    end else if (flush) begin
      mq.delete();
      mpc = {flush_pc[31:2], 2'b00};
    end else begin
      e = mq.size() < DEPTH;
      d = iq.iq_ready_i && mq.size() > 0;
      w = ram[mpc[9:2]];
      if (d) void'(mq.pop_front());
      if (e) begin
        x.pc   = mpc;
        x.inst = w;
        x.pred = is_jal(w);
        mq.push_back(x);
        mpc = nxt(mpc, w);
      end
    end
    @(posedge clk);
    #1;
    check("pc", pc, mpc);
    check("count", 32'(count), 32'(mq.size()));
    check("valid", 32'(iq.iq_valid_o),
          32'(mq.size() > 0));
    if (mq.size() == 0) begin
      check("hinst", iq.iq_inst_o, 32'h0);
      check("hpc", iq.iq_pc_o, 32'h0);
      check("hpred", 32'(iq.iq_pred_taken_o), 32'h0);
    end else begin
      check("hinst", iq.iq_inst_o, mq[0].inst);
      check("hpc", iq.iq_pc_o, mq[0].pc);
      check("hpred", 32'(iq.iq_pred_taken_o),
            32'(mq[0].pred));
    end
  endtask

  task automatic redirect(input logic [31:0] a,
                          input logic rdy);
    flush         = 1'b1;
    flush_pc      = a;
    iq.iq_ready_i = rdy;
    step();
    flush = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w[6:0] == 7'h6f) w[0] = 1'b0;
      ram[i] = w;
    end
    ram[0]   = 32'hfe010113;
    ram[1]   = 32'h00112e23;
    ram[9]   = 32'h0300006f;
    ram[100] = 32'hf9dff06f;
    ram[255] = 32'h00000013;

    rst           = 1'b1;
    flush         = 1'b0;
    flush_pc      = '0;
    iq.iq_ready_i = 1'b0;
    mpc           = RPC;
    step();
    check("rst_cnt", 32'(count), 32'h0);
    check("rst_pc", pc, RPC);

    // reset then stall
    rst = 1'b0;
    repeat (4) step();
    check("fill_cnt", 32'(count), 32'd4);
    check("fill_pc", pc, 32'h10);
    check("fill_hinst", iq.iq_inst_o, 32'hfe010113);
    check("fill_hpc", iq.iq_pc_o, 32'h0);
    step();
    check("hold_pc", pc, 32'h10);

    // drain one from full
    iq.iq_ready_i = 1'b1;
    step();
    check("drain_cnt", 32'(count), 32'd3);
    check("drain_hinst", iq.iq_inst_o, 32'h00112e23);
    check("drain_hpc", iq.iq_pc_o, 32'h4);
    iq.iq_ready_i = 1'b0;
    step();
    check("refill_cnt", 32'(count), 32'd4);

    // streaming
    redirect(32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("strm_cnt", 32'(count), 32'd1);
      check("strm_hpc", iq.iq_pc_o, 32'(4 * i));
    end

    // flush with dequeue
    redirect(32'h0, 1'b0);
    repeat (3) step();
    check("pre_fl_cnt", 32'(count), 32'd3);
    redirect(32'h103, 1'b1);
    check("fl_cnt", 32'(count), 32'd0);
    check("fl_valid", 32'(iq.iq_valid_o), 32'd0);
    check("fl_pc", pc, 32'h100);
    iq.iq_ready_i = 1'b0;
    step();
    check("fl_hpc", iq.iq_pc_o, 32'h100);

    // JAL predict
    redirect(32'h24, 1'b0);
    step();
`ifdef FETCH_JAL_PREDICT_EN
    check("jal_pc", pc, 32'h54);
    check("jal_pred", 32'(iq.iq_pred_taken_o), 32'd1);
`else
    check("jal_pc", pc, 32'h28);
    check("jal_pred", 32'(iq.iq_pred_taken_o), 32'd0);
`endif

    // PC wrap at top of address space
    redirect(32'hffff_fffc, 1'b0);
    step();
    check("wrap_pc", pc, 32'h0);

    // back-to-back flushes
    redirect(32'h40, 1'b1);
    redirect(32'h80, 1'b1);
    check("b2b_pc", pc, 32'h80);
    check("b2b_cnt", 32'(count), 32'd0);

    // reset mid-stream
    redirect(32'h0, 1'b0);
    repeat (2) step();
    rst = 1'b1;
    step();
    check("mrst_cnt", 32'(count), 32'd0);
    check("mrst_pc", pc, RPC);
    check("mrst_hinst", iq.iq_inst_o, 32'h0);
    rst = 1'b0;

    // random traffic
    for (int i = 0; i < 800; i++) begin
      iq.iq_ready_i = 1'($urandom_range(0, 1));
      flush         = ($urandom_range(0, 15) == 0);
      flush_pc      = $urandom;
      rst           = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
